// File: rtl/dealer_hand_sim.sv
// rtl/dealer_hand_sim.sv - blackjack dealer hand player with saturating statistics
//
// Purpose: plays one dealer hand per accepted start. Samples from the LFSR stage
//          are rejection-filtered to 0..25, mapped to card values, and drawn until
//          the stand threshold, a bust or the card limit ends the hand.
// Optional feature macro: SOFT_ACE_EN (ace may count 11; dealer stands on soft totals).
// Ports:
//   CLK100MHZ    in   system clock, rising edge
//   CPU_RESETN   in   asynchronous active-low reset
//   start        in   new hand request, honoured only in IDLE
//   stand_thresh in   [4:0] stand threshold, latched on accepted start
//   rand_in      in   [4:0] random sample
//   rand_valid   in   rand_in usable this cycle
//   busy         out  accepted start through done pulse
//   done         out  one-cycle hand-finished pulse
//   final_total  out  [4:0] last hand total, saturated at 31
//   card_count   out  [3:0] cards in last hand
//   bust         out  last hand total > 21
//   hand_count   out  [STAT_W-1:0] finished hands, saturating
//   bust_count   out  [STAT_W-1:0] busted hands, saturating
module dealer_hand_sim #(
   parameter int MAX_CARDS = 11,
   parameter int STAT_W    = 16
) (
   input  logic              CLK100MHZ,
   input  logic              CPU_RESETN,
   input  logic              start,
   input  logic [4:0]        stand_thresh,
   input  logic [4:0]        rand_in,
   input  logic              rand_valid,
   output logic              busy,
   output logic              done,
   output logic [4:0]        final_total,
   output logic [3:0]        card_count,
   output logic              bust,
   output logic [STAT_W-1:0] hand_count,
   output logic [STAT_W-1:0] bust_count
);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;

   localparam logic [3:0] MAX_C = 4'(MAX_CARDS);

   state_t              state_q, state_d;
   logic [4:0]          thresh_q, thresh_d;
   logic [5:0]          total_q, total_d;
   logic [3:0]          count_q, count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [4:0]          final_total_q, final_total_d;
   logic [3:0]          card_count_q, card_count_d;
   logic                bust_q, bust_d;
   logic [STAT_W-1:0]   hand_count_q, hand_count_d;
   logic [STAT_W-1:0]   bust_count_q, bust_count_d;

   logic                accept;
   logic [4:0]          rank_idx;
   logic [3:0]          rank;
   logic [5:0]          value;
   logic [5:0]          new_total;
   logic [3:0]          new_count;
   logic                stop;
`ifdef SOFT_ACE_EN
   logic                soft_q, soft_d;
   logic                new_soft;
   logic [5:0]          raw_total;
`endif

   // Samples 26..31 are rejected so each of the 13 ranks appears exactly twice.
   assign accept   = (state_q == S_DRAW) && rand_valid && (rand_in < 5'd26);
   assign rank_idx = (rand_in >= 5'd13) ? (rand_in - 5'd13) : rand_in;
   assign rank     = rank_idx[3:0] + 4'd1;
   assign new_count = count_q + 4'd1;

   always_comb begin
      value = (rank > 4'd10) ? 6'd10 : {2'b00, rank};
`ifdef SOFT_ACE_EN
      new_soft = soft_q;
      if (rank == 4'd1 && !soft_q && (total_q + 6'd11 <= 6'd21)) begin
         value    = 6'd11;
         new_soft = 1'b1;
      end
      raw_total = total_q + value;
      new_total = raw_total;
      // A soft ace falls back to 1 before the stop test sees the total.
      if (raw_total > 6'd21 && new_soft) begin
         new_total = raw_total - 6'd10;
         new_soft  = 1'b0;
      end
`else
      new_total = total_q + value;
`endif
   end

   assign stop = (new_count >= 4'd2) &&
                 ((new_total >= {1'b0, thresh_q}) || (new_total > 6'd21) || (new_count == MAX_C));

   always_comb begin
      state_d       = state_q;
      thresh_d      = thresh_q;
      total_d       = total_q;
      count_d       = count_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      final_total_d = final_total_q;
      card_count_d  = card_count_q;
      bust_d        = bust_q;
      hand_count_d  = hand_count_q;
      bust_count_d  = bust_count_q;
`ifdef SOFT_ACE_EN
      soft_d        = soft_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               thresh_d = stand_thresh;
               total_d  = 6'd0;
               count_d  = 4'd0;
               busy_d   = 1'b1;
               state_d  = S_DRAW;
`ifdef SOFT_ACE_EN
               soft_d   = 1'b0;
`endif
            end
         end
         S_DRAW: begin
            if (accept) begin
               total_d = new_total;
               count_d = new_count;
`ifdef SOFT_ACE_EN
               soft_d  = new_soft;
`endif
               if (stop) begin
                  // Results land with the transition so they are valid alongside done.
                  state_d       = S_FINISH;
                  done_d        = 1'b1;
                  final_total_d = (new_total > 6'd31) ? 5'd31 : new_total[4:0];
                  card_count_d  = new_count;
                  bust_d        = (new_total > 6'd21);
                  if (!(&hand_count_q))
                     hand_count_d = hand_count_q + 1'b1;
                  if ((new_total > 6'd21) && !(&bust_count_q))
                     bust_count_d = bust_count_q + 1'b1;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q       <= S_IDLE;
         thresh_q      <= '0;
         total_q       <= '0;
         count_q       <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         final_total_q <= '0;
         card_count_q  <= '0;
         bust_q        <= 1'b0;
         hand_count_q  <= '0;
         bust_count_q  <= '0;
`ifdef SOFT_ACE_EN
         soft_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         thresh_q      <= thresh_d;
         total_q       <= total_d;
         count_q       <= count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         final_total_q <= final_total_d;
         card_count_q  <= card_count_d;
         bust_q        <= bust_d;
         hand_count_q  <= hand_count_d;
         bust_count_q  <= bust_count_d;
`ifdef SOFT_ACE_EN
         soft_q        <= soft_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign final_total = final_total_q;
   assign card_count  = card_count_q;
   assign bust        = bust_q;
   assign hand_count  = hand_count_q;
   assign bust_count  = bust_count_q;

endmodule
